// File: rtl/uart_fifo_ctrl_pkg.sv
// uart_pkg: register map offsets, STAT/CTRL bit positions, TX FSM state
// encodings, the sticky-flag record and the watermark clamp helper shared
// by the UART FIFO controller.
package uart_pkg;

  localparam logic [7:0] OFF_RX_DATA = 8'h00;
  localparam logic [7:0] OFF_TX_DATA = 8'h04;
  localparam logic [7:0] OFF_STAT    = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h0C;
  localparam logic [7:0] OFF_COUNT   = 8'h10;

  localparam int STAT_RX_EMPTY  = 0;
  localparam int STAT_RX_FULL   = 1;
  localparam int STAT_TX_EMPTY  = 2;
  localparam int STAT_TX_FULL   = 3;
  localparam int STAT_RX_OVR    = 4;
  localparam int STAT_FRAME_ERR = 5;
  localparam int STAT_TX_OVR    = 6;
  localparam int STAT_RX_WM     = 7;
  localparam int STAT_RX_TO     = 8;

  localparam int CTRL_RX_WM_IE    = 0;
  localparam int CTRL_TX_EMPTY_IE = 1;
  localparam int CTRL_RX_TO_IE    = 2;
  localparam int CTRL_WM_LSB      = 8;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_WAIT  = 2'd2;
  localparam logic [1:0] TX_BUSY  = 2'd3;

  // Sticky status flags, cleared together by a STAT read.
  typedef struct packed {
    logic rx_to;
    logic tx_ovr;
    logic frame_err;
    logic rx_ovr;
  } sticky_t;

  // A programmed watermark of 0 behaves as 1; values past the FIFO depth clamp to it.
  function automatic logic [15:0] wm_effective(input logic [7:0] wm, input logic [15:0] depth);
    logic [15:0] w;
    w = {8'h00, wm};
    if (w == 16'h0000) begin
      return 16'h0001;
    end else if (w > depth) begin
      return depth;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/uart_fifo_ctrl_if.sv
// Wishbone-style register bus between the slave decode and the UART
// FIFO controller. The controller takes the slave modport.
interface uart_fifo_ctrl_if;
  logic        i_wb_valid;
  logic [31:0] i_wb_adr;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport slave (
    input  i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    output o_wb_ack, o_wb_dat
  );

  modport master (
    output i_wb_valid, i_wb_adr, i_wb_we, i_wb_dat, i_wb_sel,
    input  o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/uart_fifo_ctrl_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with full/empty/count and a
// same-cycle push+pop where the pop is taken first, so a full FIFO
// still accepts a push when it is popped in that cycle.
module uart_sync_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: pops need data, pushes need room unless a pop frees it.
  always_comb begin
    do_pop  = pop && (cnt != {CW{1'b0}});
    do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      cnt    <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == {CW{1'b0}});
  assign count = cnt;

endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: Wishbone-mapped UART controller with RX/TX FIFOs,
// RX watermark, TX-empty and RX idle-timeout interrupt sources.
// Optional feature macro: UART_FIFO_CTRL_RX_TIMEOUT_EN enables the RX
// idle-timeout counter (STAT[8], CTRL[2]); without it both read as 0.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADR      = 32'h3000_0000,
  parameter int          DATA_W        = 8,
  parameter int          RX_DEPTH      = 8,
  parameter int          TX_DEPTH      = 8,
  parameter int          TIMEOUT_CHARS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_clk_div,
  uart_fifo_ctrl_if.slave   wb,
  input  logic [DATA_W-1:0] i_rx,
  input  logic              i_byte_finish,
  input  logic              i_frame_err,
  output logic [DATA_W-1:0] o_tx,
  output logic              o_tx_start,
  input  logic              i_tx_busy,
  output logic              o_irq
);

  localparam int RX_CW = $clog2(RX_DEPTH + 1);
  localparam int TX_CW = $clog2(TX_DEPTH + 1);
`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  localparam logic [2:0] IE_MASK = 3'b111;
`else
  localparam logic [2:0] IE_MASK = 3'b011;
`endif

  logic              req, rd_req, wr_req;
  logic              hit_rx, hit_tx, hit_stat, hit_ctrl, hit_count;
  logic              rx_push, rx_push_acc, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic [RX_CW-1:0]  rx_count;
  logic              tx_wr, tx_push, tx_pop, tx_full, tx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic              stat_clr, to_set, rx_wm;
  sticky_t           sticky, sticky_set;
  logic [2:0]        ie;
  logic [7:0]        wm;
  logic [15:0]       wm_eff;
  logic [31:0]       stat_word, rdat;
  logic [1:0]        tx_state;
  logic [1:0]        wait_cnt;
  logic              unused_bits;

  assign unused_bits = &{1'b0, wb.i_wb_dat[31:16]};

  // Bus request decode and FIFO handshakes for this cycle.
  always_comb begin
    req         = wb.i_wb_valid && !wb.o_wb_ack;
    rd_req      = req && !wb.i_wb_we;
    wr_req      = req && wb.i_wb_we && (wb.i_wb_sel != 4'b0000);
    hit_rx      = (wb.i_wb_adr == BASE_ADR + {24'h000000, OFF_RX_DATA});
    hit_tx      = (wb.i_wb_adr == BASE_ADR + {24'h000000, OFF_TX_DATA});
    hit_stat    = (wb.i_wb_adr == BASE_ADR + {24'h000000, OFF_STAT});
    hit_ctrl    = (wb.i_wb_adr == BASE_ADR + {24'h000000, OFF_CTRL});
    hit_count   = (wb.i_wb_adr == BASE_ADR + {24'h000000, OFF_COUNT});
    rx_pop      = rd_req && hit_rx && !rx_empty;
    rx_push     = i_byte_finish && !i_frame_err;
    rx_push_acc = rx_push && (!rx_full || rx_pop);
    tx_wr       = wr_req && hit_tx;
    tx_push     = tx_wr && !tx_full;
    tx_pop      = (tx_state == TX_IDLE) && !tx_empty && !i_tx_busy;
    stat_clr    = rd_req && hit_stat;
    sticky_set.rx_ovr    = rx_push && !rx_push_acc;
    sticky_set.frame_err = i_byte_finish && i_frame_err;
    sticky_set.tx_ovr    = tx_wr && tx_full;
    sticky_set.rx_to     = to_set;
  end

  uart_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(i_rx),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  uart_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wb.i_wb_dat[DATA_W-1:0]),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  logic [31:0] to_cnt, to_thr;
  logic        to_clear;

  // Idle threshold in clocks and the one-shot crossing that raises rx_to.
  always_comb begin
    to_thr   = i_clk_div * 32'(TIMEOUT_CHARS * (DATA_W + 2));
    to_clear = rx_push_acc || rx_pop || rx_empty;
    to_set   = !to_clear && (to_cnt < to_thr) && ((to_cnt + 32'd1) == to_thr);
  end

  // Saturating idle counter, restarted by any RX traffic or an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= 32'd0;
    end else if (to_clear) begin
      to_cnt <= 32'd0;
    end else if (to_cnt < to_thr) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  logic unused_div;
  assign unused_div = &{1'b0, i_clk_div};
  assign to_set     = 1'b0;
`endif

  // Status word and read-data mux; write-only and unmapped addresses read 0.
  always_comb begin
    wm_eff    = wm_effective(wm, 16'(RX_DEPTH));
    rx_wm     = (16'(rx_count) >= wm_eff);
    stat_word = 32'h0000_0000;
    stat_word[STAT_RX_EMPTY]  = rx_empty;
    stat_word[STAT_RX_FULL]   = rx_full;
    stat_word[STAT_TX_EMPTY]  = tx_empty;
    stat_word[STAT_TX_FULL]   = tx_full;
    stat_word[STAT_RX_OVR]    = sticky.rx_ovr;
    stat_word[STAT_FRAME_ERR] = sticky.frame_err;
    stat_word[STAT_TX_OVR]    = sticky.tx_ovr;
    stat_word[STAT_RX_WM]     = rx_wm;
    stat_word[STAT_RX_TO]     = sticky.rx_to;
    if (hit_rx) begin
      rdat = rx_empty ? 32'h0000_0000 : 32'(rx_head);
    end else if (hit_stat) begin
      rdat = stat_word;
    end else if (hit_ctrl) begin
      rdat = {16'h0000, wm, 5'b00000, ie};
    end else if (hit_count) begin
      rdat = {16'(tx_count), 16'(rx_count)};
    end else begin
      rdat = 32'h0000_0000;
    end
  end

  // Single-cycle acknowledge with registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb.o_wb_ack <= 1'b0;
      wb.o_wb_dat <= 32'h0000_0000;
    end else begin
      wb.o_wb_ack <= req;
      wb.o_wb_dat <= rd_req ? rdat : 32'h0000_0000;
    end
  end

  // CTRL register; the timeout enable bit only sticks when the feature is built in.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie <= 3'b000;
      wm <= 8'h01;
    end else if (wr_req && hit_ctrl) begin
      ie <= wb.i_wb_dat[2:0] & IE_MASK;
      wm <= wb.i_wb_dat[CTRL_WM_LSB +: 8];
    end
  end

  // Sticky flags: a STAT read clears them, a same-cycle event sets them again.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '{default: 1'b0};
    end else begin
      sticky <= sticky_t'((stat_clr ? 4'b0000 : 4'(sticky)) | 4'(sticky_set));
    end
  end

  // Level interrupt, registered one cycle behind its sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= (rx_wm & ie[CTRL_RX_WM_IE]) | (tx_empty & ie[CTRL_TX_EMPTY_IE]) |
               (sticky.rx_to & ie[CTRL_RX_TO_IE]);
    end
  end

  // TX sequencer: pop, strobe start, wait for the serialiser to go busy (max 4 cycles), then idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      wait_cnt   <= 2'd0;
      o_tx       <= {DATA_W{1'b0}};
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            o_tx       <= tx_head;
            o_tx_start <= 1'b1;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          wait_cnt <= 2'd0;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (i_tx_busy || (wait_cnt == 2'd3)) begin
            tx_state <= TX_BUSY;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        TX_BUSY: begin
          if (!i_tx_busy) begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: directed scenarios plus a
// randomized register/RX traffic phase compared against a queue-based model.
module tb_uart_fifo_ctrl;
  import uart_pkg::*;

  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam int          DATA_W   = 8;
  localparam int          RX_DEPTH = 8;
  localparam int          TX_DEPTH = 8;
`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
  localparam logic [2:0] IE_MASK = 3'b111;
`else
  localparam logic [2:0] IE_MASK = 3'b011;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       clk_div = 32'd1000;
  logic [DATA_W-1:0] rx = '0;
  logic              byte_finish = 1'b0;
  logic              frame_err = 1'b0;
  logic [DATA_W-1:0] tx;
  logic              tx_start;
  logic              tx_busy = 1'b1;
  logic              irq;

  uart_fifo_ctrl_if wb();

  uart_fifo_ctrl #(.BASE_ADR(BASE), .DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH),
                   .TX_DEPTH(TX_DEPTH), .TIMEOUT_CHARS(4)) dut (
    .clk(clk), .rst(rst), .i_clk_div(clk_div), .wb(wb),
    .i_rx(rx), .i_byte_finish(byte_finish), .i_frame_err(frame_err),
    .o_tx(tx), .o_tx_start(tx_start), .i_tx_busy(tx_busy), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  int unsigned       total = 0;
  int unsigned       bad = 0;
  logic [DATA_W-1:0] rxq[$];
  logic [DATA_W-1:0] txq[$];
  logic [DATA_W-1:0] exp_sent[$];
  bit                m_rx_ovr, m_frame_err, m_tx_ovr, m_rx_to;
  logic [31:0]       m_ctrl = 32'h0000_0100;

  // Serialiser model records (written only by the serialiser process)
  bit                hold = 1'b1;
  logic [DATA_W-1:0] s_ch[$];
  int                s_cyc[$];
  bit                s_busy[$];
  int                s_base = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_wm();
    int w;
    w = int'(m_ctrl[15:8]);
    if (w == 0) w = 1;
    if (w > RX_DEPTH) w = RX_DEPTH;
    return w;
  endfunction

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s = 32'h0;
    s[0] = (rxq.size() == 0);
    s[1] = (rxq.size() == RX_DEPTH);
    s[2] = (txq.size() == 0);
    s[3] = (txq.size() == TX_DEPTH);
    s[4] = m_rx_ovr;
    s[5] = m_frame_err;
    s[6] = m_tx_ovr;
    s[7] = (rxq.size() >= m_wm());
    s[8] = m_rx_to;
    return s;
  endfunction

  function automatic logic m_irq();
    return ((rxq.size() >= m_wm()) && m_ctrl[0]) || ((txq.size() == 0) && m_ctrl[1]) ||
           (m_rx_to && m_ctrl[2]);
  endfunction

  // Serialiser: goes busy for 20 cycles after each start unless held busy.
  initial begin
    int cyc = 0;
    int busy_left = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin
        s_ch.push_back(tx);
        s_cyc.push_back(cyc);
        s_busy.push_back(tx_busy);
        busy_left = 20;
      end
      if (hold) tx_busy = 1'b1;
      else if (busy_left > 0) begin tx_busy = 1'b1; busy_left--; end
      else tx_busy = 1'b0;
    end
  end

  task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdata);
    @(negedge clk);
    wb.i_wb_valid = 1'b1; wb.i_wb_we = we; wb.i_wb_adr = adr;
    wb.i_wb_dat = dat; wb.i_wb_sel = sel;
    @(negedge clk);
    wb.i_wb_valid = 1'b0;
    chk("ack", {31'b0, wb.o_wb_ack}, 32'd1);
    rdata = wb.o_wb_dat;
    @(negedge clk);
    chk("ack_single", {31'b0, wb.o_wb_ack}, 32'd0);
  endtask

  task automatic rd_rx();
    logic [31:0] d, e;
    bus(1'b0, BASE + 32'h00, 32'h0, 4'hF, d);
    e = (rxq.size() != 0) ? 32'(rxq.pop_front()) : 32'h0;
    chk("rx_data", d, e);
  endtask

  task automatic rd_stat();
    logic [31:0] d;
    bus(1'b0, BASE + 32'h08, 32'h0, 4'hF, d);
    chk("stat", d, m_stat());
    m_rx_ovr = 0; m_frame_err = 0; m_tx_ovr = 0; m_rx_to = 0;
  endtask

  task automatic rd_count();
    logic [31:0] d;
    bus(1'b0, BASE + 32'h10, 32'h0, 4'hF, d);
    chk("count", d, {16'(txq.size()), 16'(rxq.size())});
  endtask

  task automatic rd_ctrl();
    logic [31:0] d;
    bus(1'b0, BASE + 32'h0C, 32'h0, 4'hF, d);
    chk("ctrl", d, m_ctrl);
  endtask

  task automatic wr_ctrl(input logic [31:0] v, input logic [3:0] sel);
    logic [31:0] d;
    bus(1'b1, BASE + 32'h0C, v, sel, d);
    if (sel != 4'h0) m_ctrl = {16'h0, v[15:8], 5'h0, v[2:0] & IE_MASK};
  endtask

  task automatic wr_tx(input logic [31:0] v, input logic [3:0] sel);
    logic [31:0] d;
    bus(1'b1, BASE + 32'h04, v, sel, d);
    if (sel != 4'h0) begin
      if (txq.size() == TX_DEPTH) m_tx_ovr = 1;
      else begin txq.push_back(v[DATA_W-1:0]); exp_sent.push_back(v[DATA_W-1:0]); end
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] c, input bit ferr);
    @(negedge clk);
    byte_finish = 1'b1; frame_err = ferr; rx = c;
    @(negedge clk);
    byte_finish = 1'b0; frame_err = 1'b0;
    if (ferr) m_frame_err = 1;
    else if (rxq.size() == RX_DEPTH) m_rx_ovr = 1;
    else rxq.push_back(c);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxq.delete(); txq.delete(); exp_sent.delete();
    m_rx_ovr = 0; m_frame_err = 0; m_tx_ovr = 0; m_rx_to = 0;
    m_ctrl = 32'h0000_0100;
    s_base = s_ch.size();
  endtask

  // Let the serialiser run, then compare transmitted characters, ordering and spacing.
  task automatic drain();
    int n = 0;
    hold = 1'b0;
    while ((s_ch.size() - s_base) < exp_sent.size() && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (30) @(negedge clk);
    chk("tx_sent", 32'(s_ch.size() - s_base), 32'(exp_sent.size()));
    for (int i = 0; i < exp_sent.size(); i++) begin
      if (s_base + i < s_ch.size()) begin
        chk("tx_char", 32'(s_ch[s_base + i]), 32'(exp_sent[i]));
        chk("tx_start_while_busy", 32'(s_busy[s_base + i]), 32'd0);
        if (i > 0) chk("tx_gap_ge3", 32'((s_cyc[s_base + i] - s_cyc[s_base + i - 1]) >= 3), 32'd1);
      end
    end
    hold = 1'b1;
    s_base = s_ch.size();
    exp_sent.delete(); txq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    wb.i_wb_valid = 1'b0; wb.i_wb_we = 1'b0; wb.i_wb_adr = 32'h0;
    wb.i_wb_dat = 32'h0; wb.i_wb_sel = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
    chk("rst_dat", wb.o_wb_dat, 32'd0);
    chk("rst_tx", 32'(tx), 32'd0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    rd_stat(); rd_ctrl(); rd_count();

    // Watermark interrupt
    wr_ctrl(32'h0000_0301, 4'hF);
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 0);
    chk("wm_irq_latency0", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("wm_irq_rise", {31'b0, irq}, 32'd1);
    rd_rx(); rd_rx(); rd_rx();
    chk("wm_irq_drop", {31'b0, irq}, 32'(m_irq()));

    // RX overflow and sticky clear
    wr_ctrl(32'h0000_0100, 4'hF);
    for (int i = 0; i < 9; i++) push(8'(8'hA0 + i), 0);
    rd_stat(); rd_stat(); rd_count();
    for (int i = 0; i < 8; i++) rd_rx();

    // Frame error, also coinciding with a STAT read
    push(8'h55, 0); push(8'h66, 1);
    rd_count(); rd_stat();
    @(negedge clk);
    wb.i_wb_valid = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_adr = BASE + 32'h08; wb.i_wb_sel = 4'hF;
    byte_finish = 1'b1; frame_err = 1'b1; rx = 8'h77;
    @(negedge clk);
    wb.i_wb_valid = 1'b0; byte_finish = 1'b0; frame_err = 1'b0;
    chk("ack", {31'b0, wb.o_wb_ack}, 32'd1);
    chk("stat_coincide", wb.o_wb_dat, m_stat());
    m_rx_ovr = 0; m_tx_ovr = 0; m_rx_to = 0; m_frame_err = 1;
    @(negedge clk);
    rd_stat(); rd_rx(); rd_count();

    // TX queue drain with a 20-cycle busy serialiser
    hold = 1'b0;
    repeat (5) @(negedge clk);
    wr_tx(32'h41, 4'hF); wr_tx(32'h42, 4'hF); wr_tx(32'h43, 4'hF);
    drain();

    // Timeout enable bit behaviour
    wr_ctrl(32'h0000_0107, 4'hF);
    rd_ctrl();
    wr_ctrl(32'h0000_0100, 4'hF);

`ifdef UART_FIFO_CTRL_RX_TIMEOUT_EN
    reset_dut();
    clk_div = 32'd10;
    wr_ctrl(32'h0000_0104, 4'hF);
    push(8'h5A, 0);
    repeat (400) @(negedge clk);
    chk("to_irq_before", {31'b0, irq}, 32'd0);
    @(negedge clk);
    chk("to_irq_after", {31'b0, irq}, 32'd1);
    m_rx_to = 1;
    rd_stat();
    reset_dut();
    wr_ctrl(32'h0000_0104, 4'hF);
    push(8'h5B, 0);
    repeat (199) @(negedge clk);
    reset_dut();
    wr_ctrl(32'h0000_0104, 4'hF);
    repeat (450) @(negedge clk);
    chk("to_after_reset_irq", {31'b0, irq}, 32'd0);
    rd_stat(); rd_count(); rd_ctrl();
    clk_div = 32'd1000;
`endif

    // Randomized register and RX traffic, TX serialiser held busy
    reset_dut();
    for (int k = 0; k < 400; k++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin push(8'($urandom), $urandom_range(0, 7) == 0); @(negedge clk); end
        3, 4:    rd_rx();
        5:       wr_tx($urandom, ($urandom_range(0, 7) == 0) ? 4'h0 : 4'hF);
        6:       rd_stat();
        7:       rd_count();
        8:       wr_ctrl({16'h0, 8'($urandom_range(0, 12)), 8'($urandom)},
                         ($urandom_range(0, 7) == 0) ? 4'h0 : 4'hF);
        default: begin
          if ($urandom_range(0, 1) == 1) rd_ctrl();
          else begin
            bus(1'b0, BASE + 32'h14, 32'h0, 4'hF, d);
            chk("unmapped_rd", d, 32'h0);
            bus(1'b1, BASE + 32'h18, $urandom, 4'hF, d);
          end
        end
      endcase
      chk("irq", {31'b0, irq}, 32'(m_irq()));
    end
    rd_stat(); rd_count();
    drain();
    rd_stat(); rd_count();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
